// File: rtl/row_mult_engine.sv
// Row x vector dot-product responder for the main_controller row handshake.
// Define MULT_SAT_EN to saturate wr_data instead of truncating it.
module row_mult_engine #(
  parameter int DATA_W = 8,
  parameter int N_COLS = 10,
  parameter int N_ROWS = 10,
  parameter int RES_W  = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              begin_mult,
  input  logic [3:0]        res_add,
  output logic              rd_en,
  output logic [3:0]        rd_row,
  output logic [3:0]        rd_col,
  input  logic [DATA_W-1:0] rd_a,
  input  logic [DATA_W-1:0] rd_b,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [RES_W-1:0]  wr_data,
  output logic              done_row
);

  localparam int ACC_W = 2*DATA_W + 4;
  localparam int PW    = 2*DATA_W;
  localparam int WW    = ACC_W + RES_W;
  localparam logic [3:0] LAST_COL = 4'(N_COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ACCUM,
    S_WRITE,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       row_q, row_d;
  logic [3:0]       col_q, col_d;
  logic [ACC_W-1:0] acc_q;
  logic             rd_v_q;
  logic             clr_acc;
  logic             req_ok;
  logic [PW-1:0]    prod;
  logic [WW-1:0]    acc_wide;
  logic [RES_W-1:0] result;

  assign req_ok = begin_mult &&
                  ({1'b0, res_add} < 5'(N_ROWS));

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      rd_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rd_v_q  <= rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    clr_acc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          row_d   = res_add;
          col_d   = '0;
          clr_acc = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!begin_mult) begin
          col_d   = '0;
          state_d = S_IDLE;
        end else if (col_q == LAST_COL) begin
          col_d   = '0;
          state_d = S_ACCUM;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      S_ACCUM: begin
        state_d = begin_mult ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        unique case (1'b1)
          !begin_mult: state_d = S_IDLE;
          (req_ok && res_add != row_q): begin
            row_d   = res_add;
            col_d   = '0;
            clr_acc = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_WAIT;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data lags rd_en by one cycle, so accumulate on the delayed strobe.
  assign prod = PW'(rd_a) * PW'(rd_b);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      acc_q <= '0;
    end else if (clr_acc) begin
      acc_q <= '0;
    end else if (rd_v_q) begin
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

  assign acc_wide = WW'(acc_q);

`ifdef MULT_SAT_EN
  assign result = (|acc_wide[WW-1:RES_W]) ?
                  {RES_W{1'b1}} :
                  acc_wide[RES_W-1:0];
`else
  logic [WW-RES_W-1:0] unused_acc_hi;
  assign unused_acc_hi = acc_wide[WW-1:RES_W];
  assign result        = acc_wide[RES_W-1:0];
`endif

  assign rd_en    = (state_q == S_FETCH);
  assign rd_row   = rd_en ? row_q : '0;
  assign rd_col   = rd_en ? col_q : '0;
  assign wr_en    = (state_q == S_WRITE);
  assign wr_addr  = wr_en ? row_q : '0;
  assign wr_data  = wr_en ? result : '0;
  assign done_row = wr_en;

endmodule

// File: tb/tb_row_mult_engine.sv
// Self-checking bench for row_mult_engine.
// Operand SRAM and expected dot products are modelled here.
module tb_row_mult_engine;

  localparam int DATA_W = 8;
  localparam int N_COLS = 10;
  localparam int N_ROWS = 10;
  localparam int RES_W  = 16;

  logic              clk = 1'b0;
  logic              n_reset;
  logic              begin_mult;
  logic [3:0]        res_add;
  logic              rd_en;
  logic [3:0]        rd_row;
  logic [3:0]        rd_col;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [RES_W-1:0]  wr_data;
  logic              done_row;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem_a [16][16];
  logic [DATA_W-1:0] mem_b [16];

  row_mult_engine #(
    .DATA_W(DATA_W),
    .N_COLS(N_COLS),
    .N_ROWS(N_ROWS),
    .RES_W (RES_W)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .begin_mult(begin_mult),
    .res_add   (res_add),
    .rd_en     (rd_en),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done_row  (done_row)
  );

  always #5 clk = ~clk;

  // One-cycle-latency SRAM; junk on unstrobed cycles.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_a <= mem_a[rd_row][rd_col];
      rd_b <= mem_b[rd_col];
    end else begin
      rd_a <= DATA_W'($urandom);
      rd_b <= DATA_W'($urandom);
    end
  end

  function automatic logic [RES_W-1:0] model(input int r);
    longint s;
    s = 0;
    for (int c = 0; c < N_COLS; c++)
      s += longint'(mem_a[r][c]) * longint'(mem_b[c]);
`ifdef MULT_SAT_EN
    if (s > 65535) s = 65535;
`endif
    return RES_W'(s);
  endfunction

  task automatic fill_random();
    for (int r = 0; r < 16; r++) begin
      mem_b[r] = DATA_W'($urandom);
      for (int c = 0; c < 16; c++)
        mem_a[r][c] = DATA_W'($urandom);
    end
  endtask

  task automatic wait_done(input int budget, output bit seen,
                           output int rd_cnt, output logic [15:0] d,
                           output logic [3:0] a, output bit wr_ok);
    seen = 0; rd_cnt = 0; d = '0; a = '0; wr_ok = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (rd_en) rd_cnt++;
      if (done_row) begin
        seen  = 1;
        d     = wr_data;
        a     = wr_addr;
        wr_ok = wr_en;
      end
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0; begin_mult = 1'b0; res_add = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_en, rd_row, rd_col, wr_en, wr_addr, wr_data, done_row} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd_en=%b rd_row=%0d rd_col=%0d wr_en=%b wr_addr=%0d wr_data=%0h done=%b want all 0",
               rd_en, rd_row, rd_col, wr_en, wr_addr, wr_data, done_row);
    end
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int bad_rd = 0, bad_wr = 0, bad_idx = 0;
    for (int r = 0; r < 16; r++) begin
      mem_b[r] = 8'd2;
      for (int c = 0; c < 16; c++) mem_a[r][c] = 8'(r + 1);
    end
    begin_mult = 1'b1; res_add = 4'd3;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (rd_en !== (k >= 1 && k <= N_COLS)) bad_rd++;
      if (wr_en !== (k == N_COLS + 2) || done_row !== (k == N_COLS + 2)) bad_wr++;
      if (rd_en && (rd_row !== 4'd3 || rd_col !== 4'(k - 1))) bad_idx++;
      if (k == N_COLS + 2) begin
        checks++;
        if (wr_addr !== 4'd3 || wr_data !== 16'h0050) begin
          errors++;
          $display("FAIL single_result: got addr=%0d data=%0h want addr=3 data=50",
                   wr_addr, wr_data);
        end
        begin_mult = 1'b0;
      end
    end
    checks++;
    if (bad_rd != 0) begin
      errors++;
      $display("FAIL single_rd_timing: got %0d bad cycles want 0", bad_rd);
    end
    checks++;
    if (bad_wr != 0) begin
      errors++;
      $display("FAIL single_wr_timing: got %0d bad cycles want 0", bad_wr);
    end
    checks++;
    if (bad_idx != 0) begin
      errors++;
      $display("FAIL single_rd_index: got %0d bad cycles want 0", bad_idx);
    end
  endtask

  task automatic test_rows_sweep();
    bit seen, wr_ok; int rc, pulses = 0, extra = 0;
    logic [15:0] d; logic [3:0] a;
    fill_random();
    begin_mult = 1'b1; res_add = 4'd0;
    for (int r = 0; r < N_ROWS; r++) begin
      wait_done(40, seen, rc, d, a, wr_ok);
      if (seen) pulses++;
      checks++;
      if (!seen || !wr_ok || a !== 4'(r) || d !== model(r) || rc != N_COLS) begin
        errors++;
        $display("FAIL sweep_row%0d: got seen=%b wr=%b addr=%0d data=%0h rd=%0d want addr=%0d data=%0h rd=%0d",
                 r, seen, wr_ok, a, d, rc, r, model(r), N_COLS);
      end
      if (r < N_ROWS - 1) res_add = 4'(r + 1);
    end
    repeat (40) begin
      @(negedge clk);
      if (done_row || wr_en || rd_en) extra++;
    end
    checks++;
    if (pulses != N_ROWS || extra != 0) begin
      errors++;
      $display("FAIL sweep_count: got pulses=%0d extra=%0d want %0d and 0",
               pulses, extra, N_ROWS);
    end
    begin_mult = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturate();
    bit seen, wr_ok; int rc;
    logic [15:0] d, want; logic [3:0] a;
    for (int r = 0; r < 16; r++) begin
      mem_b[r] = 8'hFF;
      for (int c = 0; c < 16; c++) mem_a[r][c] = 8'hFF;
    end
`ifdef MULT_SAT_EN
    want = 16'hFFFF;
`else
    want = 16'hEC0A;
`endif
    begin_mult = 1'b1; res_add = 4'd0;
    wait_done(40, seen, rc, d, a, wr_ok);
    checks++;
    if (!seen || d !== want || a !== 4'd0) begin
      errors++;
      $display("FAIL saturate: got seen=%b data=%0h addr=%0d want data=%0h addr=0",
               seen, d, a, want);
    end
    begin_mult = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    bit seen, wr_ok; int rc, stray = 0;
    logic [15:0] d; logic [3:0] a; logic rd6;
    fill_random();
    begin_mult = 1'b1; res_add = 4'd2;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    begin_mult = 1'b0;
    @(negedge clk);
    rd6 = rd_en;
    repeat (20) begin
      @(negedge clk);
      if (rd_en || wr_en || done_row) stray++;
    end
    checks++;
    if (rd6 !== 1'b0 || stray != 0) begin
      errors++;
      $display("FAIL abort: got rd_en_after=%b stray=%0d want 0 and 0", rd6, stray);
    end
    begin_mult = 1'b1; res_add = 4'd1;
    wait_done(40, seen, rc, d, a, wr_ok);
    checks++;
    if (!seen || a !== 4'd1 || d !== model(1) || rc != N_COLS) begin
      errors++;
      $display("FAIL abort_rerun: got seen=%b addr=%0d data=%0h rd=%0d want addr=1 data=%0h rd=%0d",
               seen, a, d, rc, model(1), N_COLS);
    end
    begin_mult = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    fill_random();
    begin_mult = 1'b1; res_add = 4'd4;
    for (int k = 1; k <= N_COLS + 1; k++) @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_en, rd_row, rd_col, wr_en, wr_addr, wr_data, done_row} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got rd_en=%b wr_en=%b wr_addr=%0d wr_data=%0h done=%b want all 0",
               rd_en, wr_en, wr_addr, wr_data, done_row);
    end
    begin_mult = 1'b0; n_reset = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (rd_en || wr_en || done_row) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_discard: got %0d active cycles want 0", stray);
    end
  endtask

  task automatic test_invalid_row();
    int act = 0;
    for (int i = 0; i < 4; i++) begin
      begin_mult = 1'b1;
      res_add = (i == 0) ? 4'd12 : 4'($urandom_range(N_ROWS, 15));
      repeat (8) begin
        @(negedge clk);
        if (rd_en || wr_en || done_row) act++;
      end
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL invalid_row: got %0d active cycles want 0", act);
    end
    begin_mult = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit seen, wr_ok; int rc, cur, nxt;
    logic [15:0] d; logic [3:0] a;
    fill_random();
    cur = $urandom_range(0, N_ROWS - 1);
    begin_mult = 1'b1; res_add = 4'(cur);
    for (int n = 0; n < 8; n++) begin
      wait_done(40, seen, rc, d, a, wr_ok);
      checks++;
      if (!seen || !wr_ok || a !== 4'(cur) || d !== model(cur)) begin
        errors++;
        $display("FAIL b2b_%0d: got seen=%b addr=%0d data=%0h want addr=%0d data=%0h",
                 n, seen, a, d, cur, model(cur));
      end
      nxt = $urandom_range(0, N_ROWS - 1);
      while (nxt == cur) nxt = $urandom_range(0, N_ROWS - 1);
      cur = nxt;
      res_add = 4'(cur);
    end
    begin_mult = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_reset = 1'b0; begin_mult = 1'b0; res_add = '0;
    test_reset();
    test_single();
    test_rows_sweep();
    test_saturate();
    test_abort();
    test_reset_mid();
    test_invalid_row();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
